multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Parametrised multi-cycle RV32I control FSM; successor to the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a req/ready handshake.
//  Adds a memory-timeout trap, an illegal-opcode trap and a retired-instruction counter.
//  Sits between instruction register, datapath muxes and the memory bus adapter.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles per memory access before bus-error trap; 0 disables timeout
//  RET_W        32  width of retired-instruction counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous active-low reset
//  opcode       in   7      instruction[6:0] from IR; valid from DECODE onward
//  mem_ready    in   1      memory completes current access this cycle
//  trap_ack     in   1      handler acknowledges trap; FSM resumes fetch
//  mem_req      out  1      memory access request (fetch or data)
//  mem_ifetch   out  1      1 = current request is instruction fetch
//  mem_we       out  1      store write enable (qualifies mem_req)
//  ir_write     out  1      load IR from memory read data
//  pc_inc       out  1      PC <= PC+4 (with ir_write)
//  pc_write     out  1      PC <= ALU/target (JAL, JALR, taken branch via branch)
//  branch       out  1      PC <= target if comparator true
//  reg_write    out  1      register-file write enable
//  mem_to_reg   out  1      WB source = load data
//  alu_src      out  1      ALU operand B = immediate
//  upper_imm    out  1      LUI/AUIPC operand select; load_upper_imm distinguishes
//  load_upper_imm out 1     1 = LUI (operand A zero), 0 = AUIPC (operand A PC)
//  alu_op       out  2      00 R-type, 01 I-arith, 10 add (addr/LUI/AUIPC/JALR), 11 branch compare
//  trap         out  1      sticky trap flag;  illegal out 1: cause=illegal opcode; bus_err out 1: cause=timeout
//  instret      out  RET_W  retired-instruction count, wraps at 2^RET_W
// BEHAVIOUR
//  States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset (rst_n=0 at edge): state=FETCH,
//   opcode latch, wait counter, instret, trap/illegal/bus_err = 0. Outputs decoded from
//   state + latched opcode, so all are 0 while rst_n low except FETCH-state outputs next cycle.
//  FETCH: mem_req=1, mem_ifetch=1. mem_ready same cycle -> ir_write=1, pc_inc=1, go DECODE.
//  DECODE: latch opcode. Unknown opcode -> TRAP with illegal=1. Else -> EXEC.
//  EXEC by class: R -> WB (alu_op 00); I-arith -> WB (01, alu_src); LUI/AUIPC -> WB (10,
//   alu_src, upper_imm); load/store -> MEM (10, alu_src); branch: branch=1, alu_op 11, retire,
//   -> FETCH; JAL/JALR: pc_write=1, reg_write=1 (PC+4 writeback), retire, -> FETCH.
//  MEM: mem_req=1, mem_we=store. On mem_ready: store retires -> FETCH; load -> WB.
//  WB: reg_write=1, mem_to_reg=load; retire -> FETCH.
//  Latency (zero wait): branch/JAL/JALR 3, R/I/U/store 4, load 5 cycles.
//  Retire: instret += 1 on leaving last state of an instruction; wraps to 0.
//  Timeout: counter clears on entering FETCH/MEM, increments each cycle req held without ready;
//   reaching MEM_TIMEOUT without ready -> TRAP, bus_err=1, no ir_write/reg_write issued.
//   mem_ready on the cycle counter hits MEM_TIMEOUT wins (access completes, no trap).
//  TRAP: all control outputs 0, trap=1 held; trap_ack -> FETCH next cycle, flags cleared.
//  A trapped instruction never retires. Reset in any state aborts the access immediately.
// TESTING
//  Reset: rst_n=0 2 cycles -> instret=0, trap=0, then FETCH with mem_req=1.
//  ADD (0110011), ready=1 always -> reg_write pulses cycle 4, instret 0->1.
//  LW (0000011), ready delayed 3 cycles in MEM -> mem_to_reg+reg_write in WB, 8 cycles total.
//  SW (0100011) -> mem_we=1 in MEM, reg_write never 1; BEQ -> branch=1, alu_op=11 in EXEC.
//  Opcode 7'h7F -> TRAP, illegal=1, instret unchanged; trap_ack -> FETCH, flags 0.
//  MEM_TIMEOUT=4, ready held 0 in FETCH -> trap & bus_err after 4 cycles; instret at 2^RET_W-1 + retire -> 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over one memory port,
// with illegal-opcode and memory-timeout traps plus a retired-instruction counter.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             trap_ack,
  output logic             mem_req,
  output logic             mem_ifetch,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_write,
  output logic             branch,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             upper_imm,
  output logic             load_upper_imm,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic             illegal,
  output logic             bus_err,
  output logic [RET_W-1:0] instret
);

  localparam int unsigned TW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM =
    TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    C_BAD, C_R, C_I, C_LUI, C_AUIPC,
    C_LD, C_ST, C_BR, C_JAL, C_JALR
  } cls_e;

  function automatic cls_e classify(input logic [6:0] op);
    cls_e c;
    unique case (op)
      OP_R:     c = C_R;
      OP_I:     c = C_I;
      OP_LUI:   c = C_LUI;
      OP_AUIPC: c = C_AUIPC;
      OP_LD:    c = C_LD;
      OP_ST:    c = C_ST;
      OP_BR:    c = C_BR;
      OP_JAL:   c = C_JAL;
      OP_JALR:  c = C_JALR;
      default:  c = C_BAD;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [6:0]       opc_q, opc_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [RET_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  cls_e       cls_in, cls;
  logic       retire, tmo;
  logic [1:0] ac_op;
  logic       ac_src, ac_up, ac_lui;

  assign cls_in = classify(opcode);
  assign cls    = classify(opc_q);

  // ALU controls per latched class, held through EXEC/MEM/WB
  always_comb begin
    ac_op  = 2'b00;
    ac_src = 1'b0;
    ac_up  = 1'b0;
    ac_lui = 1'b0;
    unique case (cls)
      C_I: begin
        ac_op  = 2'b01;
        ac_src = 1'b1;
      end
      C_LUI, C_AUIPC: begin
        ac_op  = 2'b10;
        ac_src = 1'b1;
        ac_up  = 1'b1;
        ac_lui = (cls == C_LUI);
      end
      C_LD, C_ST, C_JAL, C_JALR: begin
        ac_op  = 2'b10;
        ac_src = 1'b1;
      end
      C_BR:    ac_op = 2'b11;
      default: ac_op = 2'b00;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    opc_d          = opc_q;
    wait_d         = '0;
    illegal_d      = illegal_q;
    bus_err_d      = bus_err_q;
    retire         = 1'b0;
    mem_req        = 1'b0;
    mem_ifetch     = 1'b0;
    mem_we         = 1'b0;
    ir_write       = 1'b0;
    pc_inc         = 1'b0;
    pc_write       = 1'b0;
    branch         = 1'b0;
    reg_write      = 1'b0;
    mem_to_reg     = 1'b0;
    alu_src        = 1'b0;
    upper_imm      = 1'b0;
    load_upper_imm = 1'b0;
    alu_op         = 2'b00;
    trap           = 1'b0;
    tmo = (MEM_TIMEOUT != 0) && (wait_q == TLIM) && !mem_ready;

    unique case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        mem_ifetch = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else if (MEM_TIMEOUT != 0) begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_DECODE: begin
        opc_d = opcode;
        if (cls_in == C_BAD) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op         = ac_op;
        alu_src        = ac_src;
        upper_imm      = ac_up;
        load_upper_imm = ac_lui;
        unique case (cls)
          C_R, C_I, C_LUI, C_AUIPC: state_d = S_WB;
          C_LD, C_ST:               state_d = S_MEM;
          C_BR: begin
            branch  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_JAL, C_JALR: begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == C_ST);
        alu_op  = ac_op;
        alu_src = ac_src;
        if (mem_ready) begin
          if (cls == C_ST) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else if (MEM_TIMEOUT != 0) begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_WB: begin
        reg_write      = 1'b1;
        mem_to_reg     = (cls == C_LD);
        alu_op         = ac_op;
        alu_src        = ac_src;
        upper_imm      = ac_up;
        load_upper_imm = ac_lui;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
        if (trap_ack) begin
          illegal_d = 1'b0;
          bus_err_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    instret_d = instret_q + RET_W'(retire);

    // reset kills any in-flight access on the bus immediately
    if (!rst_n) begin
      mem_req        = 1'b0;
      mem_ifetch     = 1'b0;
      mem_we         = 1'b0;
      ir_write       = 1'b0;
      pc_inc         = 1'b0;
      pc_write       = 1'b0;
      branch         = 1'b0;
      reg_write      = 1'b0;
      mem_to_reg     = 1'b0;
      alu_src        = 1'b0;
      upper_imm      = 1'b0;
      load_upper_imm = 1'b0;
      alu_op         = 2'b00;
      trap           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign instret = instret_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule
